// File: rtl/light_gun_pkg.sv
// rtl/light_gun_pkg.sv - shared light-gun state encoding and sequence-length defaults
package light_gun_pkg;

  localparam int DEF_DEB_CYCLES = 250000;
  localparam int DEF_MIN_LIGHT  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DARK,
    ST_BRIGHT,
    ST_REPORT,
    ST_WAIT_RELEASE
  } gun_state_t;

endpackage

// File: rtl/light_gun_frontend_debounce.sv
// rtl/light_gun_frontend_debounce.sv - two-flop synchroniser plus stable-count debouncer
module debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
      // Any cycle where the input agrees with the output restarts the stability window.
      if (sync1 == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/light_gun_frontend.sv
// rtl/light_gun_frontend.sv - light-gun pin conditioning and black/white frame hit detection
module light_gun_frontend
  import light_gun_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int MIN_LIGHT  = DEF_MIN_LIGHT
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_raw,
  input  logic light_raw,
  input  logic frame_tick,
  input  logic valid,
  output logic trigger,
  output logic detect,
  output logic busy
);

  localparam int LW = $clog2(MIN_LIGHT + 1);
  localparam logic [LW-1:0] FULL = LW'(MIN_LIGHT);

  gun_state_t    state;
  logic          light_m;
  logic          light_s;
  logic          trig_q;
  logic          trig_rise;
  logic [LW-1:0] light_cnt;
  logic          lit_pix;
  logic          lit;
  logic          dark_bad;

  debounce #(
    .CYCLES(DEB_CYCLES)
  ) u_trig_deb (
    .clk (clk),
    .rst (rst),
    .din (trig_raw),
    .dout(trigger)
  );

  assign trig_rise = trigger & ~trig_q;
  assign lit_pix   = valid & light_s;
  assign lit       = (light_cnt == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      light_m   <= 1'b0;
      light_s   <= 1'b0;
      trig_q    <= 1'b0;
      light_cnt <= '0;
    end else begin
      light_m <= light_raw;
      light_s <= light_m;
      trig_q  <= trigger;
      // A lit pixel on the tick cycle already belongs to the new frame.
      if (frame_tick) begin
        light_cnt <= lit_pix ? LW'(1) : '0;
      end else if (lit_pix && !lit) begin
        light_cnt <= light_cnt + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dark_bad <= 1'b0;
      detect   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_rise) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (frame_tick) begin
            state    <= ST_DARK;
            dark_bad <= 1'b0;
          end
        end
        ST_DARK: begin
          if (lit) dark_bad <= 1'b1;
          if (frame_tick) state <= ST_BRIGHT;
        end
        ST_BRIGHT: begin
          if (lit && !dark_bad) detect <= 1'b1;
          // Light first reaching threshold on the leaving tick still scores.
          if (frame_tick) begin
            state <= (detect || (lit && !dark_bad)) ? ST_REPORT : ST_WAIT_RELEASE;
          end
        end
        ST_REPORT: begin
          if (frame_tick) begin
            detect <= 1'b0;
            state  <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!trigger) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          detect <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_gun_frontend.sv
// tb/tb_light_gun_frontend.sv - directed self-checking bench for light_gun_frontend
module tb_light_gun_frontend;

  logic clk = 1'b0;
  logic rst;
  logic trig_raw;
  logic light_raw;
  logic frame_tick;
  logic valid;
  logic trigger;
  logic detect;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic det_hist  [20];
  logic busy_hist [20];
  logic trig_hist [20];
  logic any_det;

  always #5 clk = ~clk;

  light_gun_frontend #(
    .DEB_CYCLES(4),
    .MIN_LIGHT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig_raw  (trig_raw),
    .light_raw (light_raw),
    .frame_tick(frame_tick),
    .valid     (valid),
    .trigger   (trigger),
    .detect    (detect),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // 20-cycle frame: valid on cycles 4..15, frame_tick on cycle 19.
  task automatic run_frame(input int lit_start, input int lit_n, input int rst_at);
    for (int c = 0; c < 20; c++) begin
      valid      = (c >= 4 && c < 16);
      light_raw  = (c >= lit_start && c < lit_start + lit_n);
      frame_tick = (c == 19);
      rst        = (c == rst_at);
      step();
      det_hist[c]  = detect;
      busy_hist[c] = busy;
      trig_hist[c] = trigger;
    end
    valid      = 1'b0;
    light_raw  = 1'b0;
    frame_tick = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic press();
    trig_raw = 1'b1;
    repeat (6) step();
    chk("press_trigger", trigger, 1'b1);
    step();
    chk("press_busy", busy, 1'b1);
  endtask

  task automatic release_trig();
    trig_raw = 1'b0;
    repeat (6) step();
    chk("release_trigger", trigger, 1'b0);
    step();
    chk("release_idle", busy, 1'b0);
  endtask

  task automatic scan_detect();
    any_det = 1'b0;
    for (int c = 0; c < 20; c++) any_det = any_det | det_hist[c];
  endtask

  initial begin
    rst        = 1'b1;
    trig_raw   = 1'b0;
    light_raw  = 1'b0;
    frame_tick = 1'b0;
    valid      = 1'b0;
    step();
    step();
    chk("reset_trigger", trigger, 1'b0);
    chk("reset_detect", detect, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // Bounce, then a clean final rising edge.
    for (int i = 0; i < 8; i++) begin
      trig_raw = ((i / 2) % 2 == 0);
      step();
      chk("bounce_trigger", trigger, 1'b0);
      chk("bounce_busy", busy, 1'b0);
    end
    trig_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("deb_early_trigger", trigger, 1'b0);
      chk("deb_early_busy", busy, 1'b0);
    end
    step();
    chk("deb_trigger_6", trigger, 1'b1);
    step();
    chk("armed_busy", busy, 1'b1);

    // Clean hit.
    run_frame(99, 0, -1);
    chk("armed_frame_detect", det_hist[19], 1'b0);
    run_frame(99, 0, -1);
    chk("dark_frame_detect", det_hist[19], 1'b0);
    run_frame(4, 5, -1);
    chk("hit_before_3rd", det_hist[8], 1'b0);
    chk("hit_rise", det_hist[9], 1'b1);
    chk("hit_tick_cycle", det_hist[18], 1'b1);
    chk("hit_after_tick", det_hist[19], 1'b1);
    run_frame(99, 0, -1);
    chk("report_tick_cycle", det_hist[18], 1'b1);
    chk("report_fall", det_hist[19], 1'b0);
    chk("report_wait_busy", busy_hist[19], 1'b1);

    // Held trigger: no new sequence from WAIT_RELEASE.
    run_frame(4, 5, -1);
    scan_detect();
    chk("held_no_detect", any_det, 1'b0);
    chk("held_busy", busy_hist[19], 1'b1);
    release_trig();
    press();

    // Ambient light through dark and bright frames.
    run_frame(99, 0, -1);
    run_frame(0, 20, -1);
    run_frame(0, 20, -1);
    scan_detect();
    chk("ambient_no_detect", any_det, 1'b0);
    chk("ambient_wait_busy", busy_hist[19], 1'b1);
    release_trig();

    // Miss: two lit cycles only.
    press();
    run_frame(99, 0, -1);
    run_frame(99, 0, -1);
    run_frame(4, 2, -1);
    scan_detect();
    chk("miss_no_detect", any_det, 1'b0);
    chk("miss_wait_busy", busy_hist[19], 1'b1);
    release_trig();

    // Reset in BRIGHT after detect.
    press();
    run_frame(99, 0, -1);
    run_frame(99, 0, -1);
    run_frame(4, 5, 12);
    chk("rst_pre_detect", det_hist[11], 1'b1);
    chk("rst_detect", det_hist[12], 1'b0);
    chk("rst_busy", busy_hist[12], 1'b0);
    chk("rst_trigger", trig_hist[12], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
